// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci/Lucas term streamer.
// Seeds are plain integers; users cast them to their own data width.
package fib_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_FIB   = 1'b0;
    localparam logic MODE_LUCAS = 1'b1;

    localparam int FIB_T0 = 0;
    localparam int FIB_T1 = 1;
    localparam int LUC_T0 = 2;
    localparam int LUC_T1 = 1;

endpackage

// File: rtl/fib_tag_adder.sv
// Combinational DATA_W-bit adder whose overflow tag is sticky across terms.
// Zero latency; no flow control.
module fib_tag_adder #(
    parameter int DATA_W = 17
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              a_tag,
    input  logic              b_tag,
    output logic [DATA_W-1:0] sum,
    output logic              sum_tag
);

    logic carry;

    assign {carry, sum} = {1'b0, a} + {1'b0, b};
    // Once any operand has overflowed, every later term is also out of range.
    assign sum_tag = carry | a_tag | b_tag;

endmodule

// File: rtl/fib_seq_stream.sv
// Streams Fibonacci or Lucas terms T(0)..T(n), one per clock, after a go pulse.
// First term one cycle after acceptance; no backpressure, go is ignored while busy.
module fib_seq_stream
    import fib_pkg::*;
#(
    parameter int DATA_W = 17,
    parameter int N_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_W-1:0]    n,
    input  logic              mode,
    input  logic              go,
    output logic              busy,
    output logic [DATA_W-1:0] dataOut,
    output logic              valid,
    output logic [N_W-1:0]    term_idx,
    output logic              done,
    output logic              ovf
);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] term_a;
    logic [DATA_W-1:0] term_b;
    logic [DATA_W-1:0] sum;
    logic              tag_a;
    logic              tag_b;
    logic              sum_tag;
    logic [N_W-1:0]    cnt;
    logic [N_W-1:0]    k;
    logic              accept;
    logic              last;

    fib_tag_adder #(.DATA_W(DATA_W)) u_adder (
        .a       (term_a),
        .b       (term_b),
        .a_tag   (tag_a),
        .b_tag   (tag_b),
        .sum     (sum),
        .sum_tag (sum_tag)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = RUN;
            RUN:     if (tag_a || (k == cnt)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == RUN);
        accept = (state == IDLE) && go;
        last   = (state == RUN) && (tag_a || (k == cnt));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            term_a   <= '0;
            term_b   <= '0;
            tag_a    <= 1'b0;
            tag_b    <= 1'b0;
            cnt      <= '0;
            k        <= '0;
            dataOut  <= '0;
            term_idx <= '0;
            valid    <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            valid <= 1'b0;
            done  <= 1'b0;
            if (accept) begin
                cnt    <= n;
                k      <= '0;
                term_a <= (mode == MODE_LUCAS) ? DATA_W'(LUC_T0) : DATA_W'(FIB_T0);
                term_b <= (mode == MODE_LUCAS) ? DATA_W'(LUC_T1) : DATA_W'(FIB_T1);
                tag_a  <= 1'b0;
                tag_b  <= 1'b0;
                ovf    <= 1'b0;
            end else if (busy) begin
                valid    <= 1'b1;
                done     <= last;
                term_idx <= k;
                // A tagged term ends the run with a saturated beat at its own index.
                if (tag_a) begin
                    dataOut <= '1;
                    ovf     <= 1'b1;
                end else begin
                    dataOut <= term_a;
                    if (!last) begin
                        term_a <= term_b;
                        tag_a  <= tag_b;
                        term_b <= sum;
                        tag_b  <= sum_tag;
                        k      <= k + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fib_seq_stream.sv
// Directed and randomized runs of fib_seq_stream checked against an arithmetic
// model of the Fibonacci/Lucas sequences with saturation beyond DATA_W bits.
module tb_fib_seq_stream;

    localparam int    DATA_W = 17;
    localparam int    N_W    = 5;
    localparam longint MAXV  = (64'sd1 <<< DATA_W) - 1;

    logic              clk;
    logic              reset;
    logic [N_W-1:0]    n;
    logic              mode;
    logic              go;
    logic              busy;
    logic [DATA_W-1:0] dataOut;
    logic              valid;
    logic [N_W-1:0]    term_idx;
    logic              done;
    logic              ovf;

    int checks = 0;
    int errors = 0;

    longint exp_val [0:31];
    int     exp_last;
    bit     exp_sat;
    longint prev_data = 0;
    int     prev_idx  = 0;
    bit     prev_ovf  = 0;

    fib_seq_stream #(.DATA_W(DATA_W), .N_W(N_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .n        (n),
        .mode     (mode),
        .go       (go),
        .busy     (busy),
        .dataOut  (dataOut),
        .valid    (valid),
        .term_idx (term_idx),
        .done     (done),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Full-precision sequence; any term above MAXV ends the run saturated.
    task automatic build_model(input int nn, input bit md);
        longint seq [0:31];
        seq[0] = md ? 2 : 0;
        seq[1] = 1;
        for (int i = 2; i < 32; i++) seq[i] = seq[i-1] + seq[i-2];
        exp_sat  = 0;
        exp_last = nn;
        for (int i = 0; i <= nn; i++) begin
            if (seq[i] > MAXV) begin
                exp_val[i] = MAXV;
                exp_sat    = 1;
                exp_last   = i;
                break;
            end
            exp_val[i] = seq[i];
        end
    endtask

    // Called at a negedge; returns at a negedge. With hold=1, go stays high throughout.
    task automatic do_run(input int nn, input bit md, input bit hold);
        build_model(nn, md);
        n    = N_W'(nn);
        mode = md;
        go   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("acc_busy", busy, 1);
        chk("acc_valid", valid, 0);
        chk("acc_ovf", ovf, 0);
        chk("acc_hold_data", dataOut, prev_data);
        chk("acc_hold_idx", term_idx, prev_idx);
        if (!hold) begin
            go   = 1'($urandom);
            n    = N_W'($urandom);
            mode = 1'($urandom);
        end
        for (int j = 0; j <= exp_last; j++) begin
            @(negedge clk);
            chk("beat_valid", valid, 1);
            chk("beat_data", dataOut, exp_val[j]);
            chk("beat_idx", term_idx, j);
            chk("beat_done", done, (j == exp_last));
            chk("beat_ovf", ovf, (exp_sat && j == exp_last));
            chk("beat_busy", busy, (j != exp_last));
            if (!hold) begin
                if (j < exp_last) begin
                    go   = 1'($urandom);
                    n    = N_W'($urandom);
                    mode = 1'($urandom);
                end else begin
                    go = 1'b0;
                end
            end
        end
        prev_data = exp_val[exp_last];
        prev_idx  = exp_last;
        prev_ovf  = exp_sat;
        if (!hold) begin
            @(negedge clk);
            chk("idle_valid", valid, 0);
            chk("idle_done", done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_data", dataOut, prev_data);
            chk("idle_ovf", ovf, prev_ovf);
        end
    endtask

    initial begin
        reset = 1'b0;
        n     = '0;
        mode  = 1'b0;
        go    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_data", dataOut, 0);
        chk("rst_idx", term_idx, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_rst_valid", valid, 0);
        chk("idle_after_rst_busy", busy, 0);

        do_run(24, 1'b0, 1'b0);
        do_run(10, 1'b1, 1'b0);
        do_run(31, 1'b0, 1'b0);
        do_run(0, 1'b0, 1'b0);
        do_run(0, 1'b1, 1'b0);

        do_run(3, 1'b0, 1'b1);
        do_run(3, 1'b0, 1'b1);
        do_run(3, 1'b0, 1'b0);

        // Abort mid-run once beat k=5 is on the output.
        n    = 5'd24;
        mode = 1'b0;
        go   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_abort_data", dataOut, 5);
        chk("pre_abort_idx", term_idx, 5);
        reset = 1'b0;
        #1;
        chk("abort_data", dataOut, 0);
        chk("abort_idx", term_idx, 0);
        chk("abort_valid", valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_abort_done", done, 0);
            chk("post_abort_valid", valid, 0);
        end
        prev_data = 0;
        prev_idx  = 0;
        prev_ovf  = 0;

        for (int r = 0; r < 12; r++) begin
            do_run(int'($urandom_range(0, 31)), 1'($urandom), 1'b0);
        end
        do_run(31, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fib_seq_stream.md
Name: fib_seq_stream

Overview:
- Parametrised successor to the team's single-result Fibonacci adder.
- On a `go` pulse it latches a term count `n` and a sequence mode (Fibonacci or Lucas).
- It streams every term T(0)..T(n) one per clock with a valid strobe, and flags `done` on the last term.
- Overflow beyond `DATA_W` bits is detected; the run terminates early with a saturated value.
- Sits as a stimulus/compute leaf under the lab top levels, driven by a controller or a bench.

Parameters:
- DATA_W, 17, width of the output term.
- N_W, 5, width of the requested index n (max n = 2^N_W-1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; all state is cleared while low.
- n  in  N_W  index of the last term to produce; sampled only on an accepted go.
- mode  in  1  0 = Fibonacci (T0=0, T1=1); 1 = Lucas (T0=2, T1=1); sampled with n.
- go  in  1  start request; accepted only in IDLE.
- busy  out  1  high from the cycle after acceptance through the done cycle inclusive.
- dataOut  out  DATA_W  current term; holds the last emitted value between runs.
- valid  out  1  one-cycle strobe per emitted term.
- term_idx  out  N_W  index k of the term on dataOut.
- done  out  1  one-cycle pulse coincident with the final valid.
- ovf  out  1  set with the terminating beat when a term exceeds DATA_W bits; cleared on the next accepted go.

Behaviour:
- Reset (reset=0, async): state=IDLE; dataOut=0, term_idx=0, valid=0, done=0, busy=0, ovf=0; internal a, b and cnt cleared.
- Internal term registers a and b are DATA_W bits wide plus a 1-bit overflow tag each.
  - next = a + b.
  - tag(next) = carry-out | tag(a) | tag(b).
- IDLE:
  - go=1 at edge E0 → latch n into cnt, load a=T0 and b=T1 per mode (tags 0), clear ovf, go to RUN.
- RUN, each edge:
  - If tag(a)=1: emit dataOut = all ones (2^DATA_W-1), ovf=1, valid=1, done=1, then return to IDLE.
  - Otherwise emit dataOut=a[DATA_W-1:0] with valid=1 and term_idx=k.
    - If k==cnt: done=1, go to IDLE.
    - Else: a<=b, b<=next, k++.
- Latency: T(k) is visible after edge E0+1+k, and done follows edge E0+1+n. A run takes n+1 beats with no overflow.
- n=0: a single beat emits T0 (0 or 2) with valid=done=1.
- go while busy is ignored. n and mode changes during RUN are ignored.
- go held high continuously: the run restarts in the cycle after done. One idle cycle (busy=0) always separates runs.
- reset mid-run aborts immediately to reset values; no done is produced.
- Between runs, dataOut and term_idx hold their last values; valid and done are 0.
- Overflow leaves the term_idx of the saturated beat equal to the index of the first overflowing term.

Decomposition:
- Shared package fib_pkg holds:
  - state type (IDLE, RUN);
  - mode constants MODE_FIB=0, MODE_LUCAS=1;
  - seed constants FIB_T0=0, FIB_T1=1, LUC_T0=2, LUC_T1=1.
- One sub-module, fib_tag_adder: combinational DATA_W-bit adder producing sum and the propagated overflow tag.
- FSM, counter and registers stay in fib_seq_stream.

Test Plan:
- Reset pulse, then idle → all outputs 0. Assert reset low mid-run at k=5 → outputs 0 immediately, no done.
- mode=0, n=24, go for one cycle → 25 valid beats: 0,1,1,2,3,5,…,46368. Last beat has term_idx=24, done=1, ovf=0. busy spans 25 cycles.
- mode=1, n=10 → Lucas stream 2,1,3,4,7,11,18,29,47,76,123; done on 123.
- mode=0, n=31 (DATA_W=17) → terms through F27=196418? No: F26=121393 is the last fitting term. Beat k=27 shows 131071 with ovf=1 and done=1, run ends after 28 beats.
- n=0, go → single beat dataOut=0, valid=done=1. Repeat with mode=1 → dataOut=2.
- go held high with n=3 → back-to-back runs 0,1,1,2 each, with one busy=0 cycle between them. A go pulse during busy and an n change mid-run have no effect on the stream.
